data_mem_bus: RTL and testbench

- Data-side memory stage directly downstream of the datapath.
- Consumes the datapath's WE, addrs and data_out; produces its Read_Data.
- Decodes each word address into one of three targets:
  - an internal synchronous data RAM;
  - a GPIO register block;
  - an optional compare timer.
- Registers read data with fixed one-cycle latency, matching the multicycle control unit's memory-read state.

---
 rtl/data_mem_bus.sv | 156 +++++++++++++++
 tb/tb_data_mem_bus.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_bus.sv
// data_mem_bus: data-side memory stage behind the datapath.
// Decodes each word address into the internal data RAM, the GPIO register block,
// or (when the DMEM_TIMER_EN macro is defined) a free-running compare timer.
// Read data is registered, giving a fixed one-cycle read latency.
// Optional feature macro: DMEM_TIMER_EN (timer registers, irq, STATUS bit0).
module data_mem_bus #(
  parameter int unsigned RAM_WORDS = 1024,
  parameter int unsigned GPIO_W    = 16,
  parameter logic [31:0] MMIO_BASE = 32'h0000_2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WE,
  input  logic [31:0]       addrs,
  input  logic [31:0]       data_out,
  output logic [31:0]       Read_Data,
  output logic [GPIO_W-1:0] gpio_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic              irq,
  output logic              bus_err
);

  localparam int unsigned AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  typedef enum logic [2:0] {
    T_RAM, T_GPIO_OUT, T_GPIO_IN, T_TCNT, T_TCMP, T_STATUS, T_NONE
  } target_e;

  target_e           target;
  logic [31:0]       aligned;
  logic [AW-1:0]     ram_idx;
  logic              misaligned;
  logic              wr_ok;
  logic              err_set;
  logic              clr_err;

  logic [31:0]       ram_q [RAM_WORDS];
  logic [31:0]       read_data_d, read_data_q;
  logic [GPIO_W-1:0] gpio_out_d, gpio_out_q;
  logic [GPIO_W-1:0] sync1_d, sync1_q;
  logic [GPIO_W-1:0] sync2_d, sync2_q;
  logic              bus_err_d, bus_err_q;
`ifdef DMEM_TIMER_EN
  logic [31:0]       cnt_d, cnt_q;
  logic [31:0]       cmp_d, cmp_q;
  logic              irq_d, irq_q;
  logic              clr_irq;
`endif

  assign ram_idx    = addrs[AW+1:2];
  assign misaligned = (addrs[1:0] != 2'b00);

  // Address decode on the word-aligned address; RAM takes priority.
  always_comb begin
    aligned = {addrs[31:2], 2'b00};
    target  = T_NONE;
    if (addrs < RAM_BYTES)                    target = T_RAM;
    else if (aligned == MMIO_BASE)            target = T_GPIO_OUT;
    else if (aligned == MMIO_BASE + 32'h4)    target = T_GPIO_IN;
`ifdef DMEM_TIMER_EN
    else if (aligned == MMIO_BASE + 32'h8)    target = T_TCNT;
    else if (aligned == MMIO_BASE + 32'hC)    target = T_TCMP;
`endif
    else if (aligned == MMIO_BASE + 32'h10)   target = T_STATUS;
  end

  // Write qualification and error detection.
  always_comb begin
    wr_ok   = WE && !misaligned && (target != T_NONE) && (target != T_GPIO_IN);
    err_set = (target == T_NONE) || (WE && misaligned) || (WE && (target == T_GPIO_IN));
    clr_err = wr_ok && (target == T_STATUS) && data_out[1];
  end

  // Read mux (old contents, so same-cycle writes read-before-write) and next state.
  always_comb begin
    read_data_d = '0;
    case (target)
      T_RAM:      read_data_d = ram_q[ram_idx];
      T_GPIO_OUT: read_data_d[GPIO_W-1:0] = gpio_out_q;
      T_GPIO_IN:  read_data_d[GPIO_W-1:0] = sync2_q;
`ifdef DMEM_TIMER_EN
      T_TCNT:     read_data_d = cnt_q;
      T_TCMP:     read_data_d = cmp_q;
      T_STATUS:   read_data_d[1:0] = {bus_err_q, irq_q};
`else
      T_STATUS:   read_data_d[1:0] = {bus_err_q, 1'b0};
`endif
      default:    read_data_d = '0;
    endcase

    gpio_out_d = gpio_out_q;
    if (wr_ok && (target == T_GPIO_OUT)) gpio_out_d = data_out[GPIO_W-1:0];

    sync1_d   = gpio_in;
    sync2_d   = sync1_q;
    // A new error on the same edge as a W1C clear keeps the flag set.
    bus_err_d = err_set | (bus_err_q & ~clr_err);
  end

  // Data RAM: contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_ok && (target == T_RAM)) ram_q[ram_idx] <= data_out;
  end

  // Read data, GPIO and error flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data_q <= '0;
      gpio_out_q  <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      gpio_out_q  <= gpio_out_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      bus_err_q   <= bus_err_d;
    end
  end

`ifdef DMEM_TIMER_EN
  // Timer next state: a CPU load wins over the increment; match uses the new count.
  always_comb begin
    clr_irq = wr_ok && (target == T_STATUS) && data_out[0];
    cnt_d   = cnt_q + 32'd1;
    if (wr_ok && (target == T_TCNT)) cnt_d = data_out;
    cmp_d   = cmp_q;
    if (wr_ok && (target == T_TCMP)) cmp_d = data_out;
    irq_d   = (cnt_d == cmp_q) | (irq_q & ~clr_irq);
  end

  // Timer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      cmp_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      cmp_q <= cmp_d;
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign Read_Data = read_data_q;
  assign gpio_out  = gpio_out_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_data_mem_bus.sv
// tb_data_mem_bus: scenario tests plus randomized traffic for data_mem_bus,
// checked against a behavioural model of the address map and register rules.
module tb_data_mem_bus;

  localparam int unsigned RAM_WORDS = 1024;
  localparam int unsigned GPIO_W    = 16;
  localparam logic [31:0] MMIO_BASE = 32'h0000_2000;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
`ifdef DMEM_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif
  localparam int K_RAM = 0, K_GOUT = 1, K_GIN = 2, K_CNT = 3, K_CMP = 4, K_STAT = 5, K_NONE = 6;

  logic              clk, rst, WE;
  logic [31:0]       addrs, data_out, Read_Data;
  logic [GPIO_W-1:0] gpio_out, gpio_in;
  logic              irq, bus_err;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [31:0]       m_ram [int unsigned];
  logic [GPIO_W-1:0] m_gpio, m_s1, m_s2;
  logic [31:0]       m_cnt, m_cmp, m_rd;
  logic              m_irq, m_err;
  bit                m_known;

  data_mem_bus #(.RAM_WORDS(RAM_WORDS), .GPIO_W(GPIO_W), .MMIO_BASE(MMIO_BASE)) dut (
    .clk(clk), .rst(rst), .WE(WE), .addrs(addrs), .data_out(data_out),
    .Read_Data(Read_Data), .gpio_out(gpio_out), .gpio_in(gpio_in),
    .irq(irq), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_gpio = '0; m_s1 = '0; m_s2 = '0;
    m_cnt = '0; m_cmp = '0; m_irq = 1'b0; m_err = 1'b0;
    m_rd = '0; m_known = 1'b1;
  endtask

  // Drive one cycle of inputs, advance past the edge, and update the model.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w, new_cnt;
    int kind;
    bit wr, bad, clr_i, clr_e;
    WE = we; addrs = a; data_out = d;
    @(posedge clk);
    w = a & ~32'h3;
    kind = K_NONE;
    if (a < RAM_BYTES) kind = K_RAM;
    else if (w >= MMIO_BASE && (w - MMIO_BASE) <= 32'h10) begin
      kind = K_GOUT + int'((w - MMIO_BASE) >> 2);
      if (!TIMER && (kind == K_CNT || kind == K_CMP)) kind = K_NONE;
    end
    m_known = 1'b1;
    m_rd = '0;
    case (kind)
      K_RAM:  if (m_ram.exists(a >> 2)) m_rd = m_ram[a >> 2]; else m_known = 1'b0;
      K_GOUT: m_rd = 32'(m_gpio);
      K_GIN:  m_rd = 32'(m_s2);
      K_CNT:  m_rd = m_cnt;
      K_CMP:  m_rd = m_cmp;
      K_STAT: m_rd = {30'd0, m_err, m_irq};
      default: m_rd = '0;
    endcase
    bad   = (kind == K_NONE) || (we && a[1:0] != 2'b00) || (we && kind == K_GIN);
    wr    = we && (a[1:0] == 2'b00) && kind != K_NONE && kind != K_GIN;
    clr_i = wr && kind == K_STAT && d[0];
    clr_e = wr && kind == K_STAT && d[1];
    new_cnt = (wr && kind == K_CNT) ? d : m_cnt + 32'd1;
    m_irq = TIMER && ((new_cnt == m_cmp) || (m_irq && !clr_i));
    m_err = bad || (m_err && !clr_e);
    m_cnt = new_cnt;
    if (wr && kind == K_CMP)  m_cmp = d;
    if (wr && kind == K_RAM)  m_ram[a >> 2] = d;
    if (wr && kind == K_GOUT) m_gpio = d[GPIO_W-1:0];
    m_s2 = m_s1;
    m_s1 = gpio_in;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; WE = 1'b0; addrs = '0; data_out = '0; gpio_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (Read_Data !== 32'd0) begin failures++; $display("FAIL reset_rd got=%h exp=0", Read_Data); end
    checks++; if (gpio_out !== '0) begin failures++; $display("FAIL reset_gpio got=%h exp=0", gpio_out); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus_err); end
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_preload();
    for (int unsigned i = 0; i < 16; i++) step(1'b1, i * 4, $urandom);
    step(1'b0, 32'h0, 32'h0);
    checks++; if (Read_Data !== m_ram[0]) begin failures++; $display("FAIL preload_rd0 got=%h exp=%h", Read_Data, m_ram[0]); end
  endtask

  task automatic test_ram();
    logic [31:0] old;
    old = m_ram[4];
    step(1'b1, 32'h10, 32'hDEADBEEF);
    checks++; if (Read_Data !== old) begin failures++; $display("FAIL ram_rbw got=%h exp=%h", Read_Data, old); end
    step(1'b0, 32'h10, 32'h0);
    checks++; if (Read_Data !== 32'hDEADBEEF) begin failures++; $display("FAIL ram_read got=%h exp=deadbeef", Read_Data); end
    step(1'b0, 32'h12, 32'h0);
    checks++; if (Read_Data !== 32'hDEADBEEF) begin failures++; $display("FAIL ram_misalign_rd got=%h exp=deadbeef", Read_Data); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL ram_misalign_err got=%b exp=0", bus_err); end
  endtask

  task automatic test_gpio();
    int n;
    step(1'b1, MMIO_BASE, 32'h0000A5A5);
    checks++; if (gpio_out !== 16'hA5A5) begin failures++; $display("FAIL gpio_out got=%h exp=a5a5", gpio_out); end
    step(1'b0, MMIO_BASE, 32'h0);
    checks++; if (Read_Data !== 32'h0000A5A5) begin failures++; $display("FAIL gpio_out_rd got=%h exp=0000a5a5", Read_Data); end
    gpio_in = 16'h1234;
    n = 7;
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, MMIO_BASE + 32'h4, 32'h0);
      if (Read_Data === 32'h00001234) begin n = i; break; end
    end
    checks++; if (n < 2 || n > 3) begin failures++; $display("FAIL gpio_in_latency got=%0d exp=2..3", n); end
    checks++; if (Read_Data !== 32'h00001234) begin failures++; $display("FAIL gpio_in_rd got=%h exp=00001234", Read_Data); end
  endtask

`ifdef DMEM_TIMER_EN
  task automatic test_timer();
    int n;
    step(1'b1, MMIO_BASE + 32'hC, 32'd10);
    step(1'b1, MMIO_BASE + 32'h8, 32'd0);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL timer_irq_pre got=%b exp=0", irq); end
    n = 21;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 32'h0, 32'h0);
      if (irq === 1'b1) begin n = i; break; end
    end
    checks++; if (n != 10) begin failures++; $display("FAIL timer_match_cycles got=%0d exp=10", n); end
    step(1'b1, MMIO_BASE + 32'h10, 32'h1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL timer_irq_clear got=%b exp=0", irq); end
    step(1'b1, MMIO_BASE + 32'h8, 32'hFFFF_FFFE);
    step(1'b0, MMIO_BASE + 32'h8, 32'h0);
    checks++; if (Read_Data !== 32'hFFFF_FFFE) begin failures++; $display("FAIL timer_cnt_fe got=%h exp=fffffffe", Read_Data); end
    step(1'b0, MMIO_BASE + 32'h8, 32'h0);
    checks++; if (Read_Data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL timer_cnt_ff got=%h exp=ffffffff", Read_Data); end
    step(1'b0, MMIO_BASE + 32'h8, 32'h0);
    checks++; if (Read_Data !== 32'h0) begin failures++; $display("FAIL timer_wrap got=%h exp=0", Read_Data); end
    step(1'b1, MMIO_BASE + 32'h8, 32'd9);
    step(1'b1, MMIO_BASE + 32'h10, 32'h1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL timer_set_wins got=%b exp=1", irq); end
    step(1'b1, MMIO_BASE + 32'h10, 32'h1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL timer_clear2 got=%b exp=0", irq); end
  endtask
`else
  task automatic test_timer_disabled();
    step(1'b1, MMIO_BASE + 32'h10, 32'h2);
    step(1'b0, MMIO_BASE + 32'h8, 32'h0);
    checks++; if (Read_Data !== 32'h0) begin failures++; $display("FAIL notimer_rd got=%h exp=0", Read_Data); end
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL notimer_err got=%b exp=1", bus_err); end
    step(1'b1, MMIO_BASE + 32'hC, 32'd5);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL notimer_irq got=%b exp=0", irq); end
    step(1'b1, MMIO_BASE + 32'h10, 32'h3);
    checks++; if (Read_Data !== 32'h2) begin failures++; $display("FAIL notimer_status got=%h exp=2", Read_Data); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL notimer_clr got=%b exp=0", bus_err); end
  endtask
`endif

  task automatic test_errors();
    logic [31:0] w1;
    w1 = m_ram[1];
    step(1'b1, MMIO_BASE + 32'h10, 32'h2);
    step(1'b1, 32'h0000_3000, 32'h1111_1111);
    checks++; if (Read_Data !== 32'h0) begin failures++; $display("FAIL unmapped_rd got=%h exp=0", Read_Data); end
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL unmapped_err got=%b exp=1", bus_err); end
    step(1'b1, MMIO_BASE + 32'h10, 32'h2);
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", bus_err); end
    step(1'b1, 32'h0000_0006, 32'hFFFF_FFFF);
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL misalign_wr_err got=%b exp=1", bus_err); end
    step(1'b0, 32'h0000_0004, 32'h0);
    checks++; if (Read_Data !== w1) begin failures++; $display("FAIL misalign_wr_suppr got=%h exp=%h", Read_Data, w1); end
    step(1'b1, MMIO_BASE + 32'h10, 32'h2);
    step(1'b1, MMIO_BASE + 32'h4, 32'h0000_FFFF);
    checks++; if (bus_err !== 1'b1) begin failures++; $display("FAIL gpio_in_wr_err got=%b exp=1", bus_err); end
    step(1'b0, MMIO_BASE + 32'h4, 32'h0);
    checks++; if (Read_Data !== 32'(m_s2)) begin failures++; $display("FAIL gpio_in_wr_suppr got=%h exp=%h", Read_Data, 32'(m_s2)); end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 32'h0000_3000, 32'h0);
    step(1'b0, MMIO_BASE, 32'h0);
    WE = 1'b1; addrs = MMIO_BASE; data_out = 32'h0000_5A5A;
    #3;
    rst = 1'b0;
    #1;
    checks++; if (Read_Data !== 32'h0) begin failures++; $display("FAIL rstmid_rd got=%h exp=0", Read_Data); end
    checks++; if (gpio_out !== '0) begin failures++; $display("FAIL rstmid_gpio got=%h exp=0", gpio_out); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rstmid_irq got=%b exp=0", irq); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL rstmid_err got=%b exp=0", bus_err); end
    @(posedge clk);
    #1;
    checks++; if (gpio_out !== '0) begin failures++; $display("FAIL rstmid_nowrite got=%h exp=0", gpio_out); end
    rst = 1'b1;
    WE = 1'b0; addrs = '0; data_out = '0;
    model_reset();
  endtask

  task automatic test_random();
    logic [31:0] a;
    int r;
    for (int i = 0; i < 400; i++) begin
      if (i % 8 == 0) gpio_in = GPIO_W'($urandom);
      r = $urandom_range(0, 9);
      if (r <= 4)      a = 32'($urandom_range(0, 63));
      else if (r <= 7) a = MMIO_BASE + 32'($urandom_range(0, 20));
      else if (r == 8) a = 32'h0000_3000 + 32'($urandom_range(0, 255));
      else             a = MMIO_BASE + 32'h10;
      step(1'($urandom_range(0, 1)), a, (r == 9) ? 32'($urandom_range(0, 3)) : $urandom);
      if (m_known) begin
        checks++; if (Read_Data !== m_rd) begin failures++; $display("FAIL rand_rd a=%h got=%h exp=%h", a, Read_Data, m_rd); end
      end
      checks++; if (gpio_out !== m_gpio) begin failures++; $display("FAIL rand_gpio got=%h exp=%h", gpio_out, m_gpio); end
      checks++; if (irq !== m_irq) begin failures++; $display("FAIL rand_irq got=%b exp=%b", irq, m_irq); end
      checks++; if (bus_err !== m_err) begin failures++; $display("FAIL rand_err got=%b exp=%b", bus_err, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_ram();
    test_gpio();
`ifdef DMEM_TIMER_EN
    test_timer();
`else
    test_timer_disabled();
`endif
    test_errors();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
